// File: rtl/apb_slave_regbank.sv
// APB3 completer: NUM_REGS word registers, top index is a read-only ID; APB_SLV_PSTRB_EN adds byte strobes.
// Latency: setup + 1 + WAIT_STATES cycles; regs_o trails the completing edge by one cycle.
// Backpressure: PREADY held low for WAIT_STATES access cycles; PSEL dropped mid-access aborts with no update.
module apb_slave_regbank #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int                STRB_W  = DATA_WIDTH / 8;
  localparam int                IDX_W   = ADDR_WIDTH - 2;
  localparam int                REG_IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int                CNT_W   = 4;
  localparam logic [REG_IW-1:0] ID_IDX  = REG_IW'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  WS_LAST = CNT_W'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q, state_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_nxt;
  logic [REG_IW-1:0]       idx_q;
  logic                    wr_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS-1];
  logic [IDX_W-1:0]        setup_idx;
  logic                    setup_err;
  logic                    latch;
  logic                    do_write;
  logic [DATA_WIDTH-1:0]   wr_val;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_pack;
`ifdef APB_SLV_PSTRB_EN
  logic [STRB_W-1:0]       strb_q;
`endif

  assign setup_idx = PADDR[ADDR_WIDTH-1:2];

  // Out-of-range indices are errors rather than aliases, so the full upper address is compared.
  always_comb begin
    setup_err = (PADDR[1:0] != 2'b00)
             || (setup_idx >= IDX_W'(NUM_REGS))
             || (PWRITE && (setup_idx == IDX_W'(NUM_REGS - 1)));
`ifdef APB_SLV_PSTRB_EN
    if (!PWRITE && (PSTRB != '0)) setup_err = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    latch     = 1'b0;
    do_write  = 1'b0;
    PREADY    = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          latch     = 1'b1;
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        PREADY = (cnt_q == WS_LAST);
        if (!PSEL) begin
          state_nxt = IDLE;
        end else if (PENABLE) begin
          if (PREADY) begin
            state_nxt = IDLE;
            do_write  = wr_q && !err_q;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PRDATA = '0;
    if (PREADY && !wr_q && !err_q)
      PRDATA = (idx_q == ID_IDX) ? ID_VALUE : regs_q[idx_q];
  end

  assign PSLVERR = PREADY && err_q;

  always_comb begin
    wr_val = wdata_q;
`ifdef APB_SLV_PSTRB_EN
    wr_val = regs_q[idx_q];
    for (int k = 0; k < STRB_W; k++)
      if (strb_q[k]) wr_val[k*8 +: 8] = wdata_q[k*8 +: 8];
`endif
  end

  always_comb begin
    regs_pack = '0;
    for (int i = 0; i < NUM_REGS - 1; i++)
      regs_pack[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    regs_pack[(NUM_REGS-1)*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
`ifdef APB_SLV_PSTRB_EN
      strb_q  <= '0;
`endif
      for (int i = 0; i < NUM_REGS - 1; i++)
        regs_q[i] <= '0;
      regs_o  <= {ID_VALUE, {((NUM_REGS-1)*DATA_WIDTH){1'b0}}};
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (latch) begin
        idx_q   <= setup_idx[REG_IW-1:0];
        wr_q    <= PWRITE;
        err_q   <= setup_err;
        wdata_q <= PWDATA;
`ifdef APB_SLV_PSTRB_EN
        strb_q  <= PSTRB;
`endif
      end
      if (do_write)
        regs_q[idx_q] <= wr_val;
      regs_o <= regs_pack;
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: one instance with WAIT_STATES=1, one with WAIT_STATES=0,
// randomized traffic scored against an array-based register model.
`timescale 1ns/1ps
module tb_apb_slave_regbank;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        presetn [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic [255:0] regs   [2];
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]  pstrb   [2];
`endif

  int          ws [2] = '{1, 0};
  logic [31:0] mdl [2][8];
  int          n_chk = 0;
  int          n_pass = 0;

  apb_slave_regbank #(.WAIT_STATES(1)) u_ws1 (
    .PCLK(clk), .PRESETn(presetn[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb[0]),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .regs_o(regs[0])
  );

  apb_slave_regbank #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESETn(presetn[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb[1]),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .regs_o(regs[1])
  );

  // Reference: word-indexed register array, ID slot fixed, errors leave state untouched.
  task automatic model(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] exp_rd, output bit exp_err);
    int unsigned idx;
    logic [3:0]  mask;
    idx  = addr >> 2;
    mask = 4'hF;
`ifdef APB_SLV_PSTRB_EN
    mask = strb;
`endif
    exp_err = (addr[1:0] != 2'b00) || (idx >= 8) || (wr && idx == 7);
`ifdef APB_SLV_PSTRB_EN
    if (!wr && strb != 4'h0) exp_err = 1'b1;
`endif
    exp_rd = 32'h0;
    if (!exp_err) begin
      if (wr) begin
        for (int k = 0; k < 4; k++)
          if (mask[k]) mdl[d][idx][k*8 +: 8] = data[k*8 +: 8];
      end else begin
        exp_rd = mdl[d][idx];
      end
    end
  endtask

  function automatic logic [255:0] pack_model(input int d);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = mdl[d][i];
    return v;
  endfunction

  task automatic clear_model(input int d);
    for (int i = 0; i < 7; i++) mdl[d][i] = 32'h0;
    mdl[d][7] = ID;
  endtask

  // Drives setup then access phases; returns in the PREADY cycle so a following call is back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rd, output logic err, output int cyc);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
`ifdef APB_SLV_PSTRB_EN
    pstrb[d] = strb;
`endif
    cyc = 1; rd = 'x; err = 1'bx;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      penable[d] = 1'b1;
      cyc++;
      if (pready[d] === 1'b1) begin
        rd = prdata[d]; err = pslverr[d]; done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL xfer_timeout: inst %0d addr %h no PREADY within 40 cycles", d, addr);
    end
  endtask

  task automatic do_txn(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rd, output logic err, output int cyc,
                        output logic [31:0] exp_rd, output bit exp_err);
    xfer(d, wr, addr, data, strb, rd, err, cyc);
    model(d, wr, addr, data, strb, exp_rd, exp_err);
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      presetn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = 32'h0; pwdata[d] = 32'h0;
`ifdef APB_SLV_PSTRB_EN
      pstrb[d] = 4'h0;
`endif
      clear_model(d);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (pready[d] !== 1'b0) $display("FAIL reset_pready[%0d]: got %b want 0", d, pready[d]); else n_pass++;
      n_chk++; if (pslverr[d] !== 1'b0) $display("FAIL reset_pslverr[%0d]: got %b want 0", d, pslverr[d]); else n_pass++;
      n_chk++; if (prdata[d] !== 32'h0) $display("FAIL reset_prdata[%0d]: got %h want 0", d, prdata[d]); else n_pass++;
      n_chk++; if (regs[d] !== pack_model(d)) $display("FAIL reset_regs_o[%0d]: got %h want %h", d, regs[d], pack_model(d)); else n_pass++;
      presetn[d] = 1'b1;
    end
    // An access phase with no setup must be ignored.
    psel[0] = 1'b1; penable[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++; if (pready[0] !== 1'b0) $display("FAIL stray_enable_pready: got %b want 0", pready[0]); else n_pass++;
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd, er; logic err; int cyc; bit ee;
    do_txn(0, 1'b1, 32'h04, 32'h1234_5678, 4'hF, rd, err, cyc, er, ee);
    n_chk++; if (cyc !== 3) $display("FAIL wr04_latency: got %0d want 3", cyc); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL wr04_pslverr: got %b want 0", err); else n_pass++;
    idle(0);
    n_chk++; if (regs[0][63:32] !== 32'h0) $display("FAIL regs_o_lag: got %h want 0", regs[0][63:32]); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (regs[0][63:32] !== 32'h1234_5678) $display("FAIL regs_o_reg1: got %h want 12345678", regs[0][63:32]); else n_pass++;
    do_txn(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, cyc, er, ee);
    n_chk++; if (cyc !== 3) $display("FAIL rd04_latency: got %0d want 3", cyc); else n_pass++;
    n_chk++; if (rd !== 32'h1234_5678) $display("FAIL rd04_data: got %h want 12345678", rd); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL rd04_pslverr: got %b want 0", err); else n_pass++;
    idle(0);
  endtask

  task automatic test_id();
    logic [31:0] rd, er; logic err; int cyc; bit ee;
    do_txn(0, 1'b0, 32'h1C, 32'h0, 4'h0, rd, err, cyc, er, ee);
    n_chk++; if (rd !== 32'hA9B0_0001 || err !== 1'b0) $display("FAIL id_read: got %h/%b want a9b00001/0", rd, err); else n_pass++;
    do_txn(0, 1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF, rd, err, cyc, er, ee);
    n_chk++; if (err !== 1'b1) $display("FAIL id_write_err: got %b want 1", err); else n_pass++;
    do_txn(0, 1'b0, 32'h1C, 32'h0, 4'h0, rd, err, cyc, er, ee);
    n_chk++; if (rd !== 32'hA9B0_0001) $display("FAIL id_reread: got %h want a9b00001", rd); else n_pass++;
    idle(0);
  endtask

  task automatic test_errors();
    logic [31:0] rd, er; logic err; int cyc; bit ee;
    logic [31:0] bad [3] = '{32'h20, 32'h06, 32'h1000_0004};
    for (int i = 0; i < 3; i++) begin
      do_txn(0, 1'b0, bad[i], 32'h0, 4'h0, rd, err, cyc, er, ee);
      n_chk++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL bad_read %h: got %h/%b want 0/1", bad[i], rd, err); else n_pass++;
    end
    do_txn(0, 1'b1, 32'h06, 32'h0000_DEAD, 4'hF, rd, err, cyc, er, ee);
    n_chk++; if (err !== 1'b1) $display("FAIL misaligned_write_err: got %b want 1", err); else n_pass++;
    do_txn(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, cyc, er, ee);
    n_chk++; if (rd !== 32'h1234_5678) $display("FAIL reg1_after_bad_write: got %h want 12345678", rd); else n_pass++;
    idle(0);
  endtask

  task automatic test_abort();
    logic [31:0] rd, er; logic err; int cyc; bit ee;
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h0; pwdata[0] = 32'h55;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    n_chk++; if (pready[0] !== 1'b0) $display("FAIL abort_pready_a: got %b want 0", pready[0]); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (pready[0] !== 1'b0) $display("FAIL abort_pready_b: got %b want 0", pready[0]); else n_pass++;
    do_txn(0, 1'b0, 32'h00, 32'h0, 4'h0, rd, err, cyc, er, ee);
    n_chk++; if (rd !== 32'h0) $display("FAIL abort_reg0_unchanged: got %h want 0", rd); else n_pass++;
    do_txn(0, 1'b1, 32'h00, 32'h0000_CAFE, 4'hF, rd, err, cyc, er, ee);
    n_chk++; if (err !== 1'b0) $display("FAIL cafe_write_err: got %b want 0", err); else n_pass++;
    idle(0);
    @(posedge clk); #1;
    n_chk++; if (regs[0][31:0] !== 32'h0000_CAFE) $display("FAIL cafe_regs_o: got %h want cafe", regs[0][31:0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, er; logic err; int cyc; bit ee;
    logic [31:0] a [3] = '{32'h00, 32'h08, 32'h0C};
    for (int i = 0; i < 3; i++) begin
      do_txn(1, 1'b1, a[i], 32'(i + 1), 4'hF, rd, err, cyc, er, ee);
      n_chk++; if (cyc !== 2 || err !== 1'b0) $display("FAIL b2b_write%0d: got cyc %0d err %b want 2/0", i, cyc, err); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      do_txn(1, 1'b0, a[i], 32'h0, 4'h0, rd, err, cyc, er, ee);
      n_chk++; if (cyc !== 2 || rd !== 32'(i + 1)) $display("FAIL b2b_read%0d: got cyc %0d data %h want 2/%h", i, cyc, rd, i + 1); else n_pass++;
    end
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h04; pwdata[1] = 32'h77;
    @(posedge clk); #1;
    penable[1] = 1'b1; presetn[1] = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (pready[1] !== 1'b0) $display("FAIL midreset_pready: got %b want 0", pready[1]); else n_pass++;
    presetn[1] = 1'b1; psel[1] = 1'b0; penable[1] = 1'b0;
    clear_model(1);
    for (int i = 0; i < 7; i++) begin
      do_txn(1, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, err, cyc, er, ee);
      n_chk++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL midreset_reg%0d: got %h/%b want 0/0", i, rd, err); else n_pass++;
    end
    idle(1);
  endtask

`ifdef APB_SLV_PSTRB_EN
  task automatic test_strobe();
    logic [31:0] rd, er; logic err; int cyc; bit ee;
    do_txn(0, 1'b1, 32'h08, 32'h1111_1111, 4'hF, rd, err, cyc, er, ee);
    do_txn(0, 1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, rd, err, cyc, er, ee);
    do_txn(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc, er, ee);
    n_chk++; if (rd !== 32'h11BB_11DD) $display("FAIL strobe_merge: got %h want 11bb11dd", rd); else n_pass++;
    do_txn(0, 1'b1, 32'h08, 32'h0, 4'h0, rd, err, cyc, er, ee);
    n_chk++; if (err !== 1'b0) $display("FAIL zero_strobe_err: got %b want 0", err); else n_pass++;
    do_txn(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc, er, ee);
    n_chk++; if (rd !== 32'h11BB_11DD) $display("FAIL zero_strobe_nochange: got %h want 11bb11dd", rd); else n_pass++;
    do_txn(0, 1'b0, 32'h08, 32'h0, 4'h2, rd, err, cyc, er, ee);
    n_chk++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL read_strobe_err: got %h/%b want 0/1", rd, err); else n_pass++;
    idle(0);
  endtask
`endif

  task automatic test_random();
    logic [31:0] rd, er, addr, data; logic err; int cyc; bit ee, wr; logic [3:0] strb;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3, 4: addr = $urandom_range(0, 7) * 4;
          5:             addr = $urandom_range(0, 35);
          6:             addr = 32'h20 + $urandom_range(0, 7) * 4;
          default:       addr = (($urandom | 32'h100) & 32'hFFFF_FFE0) | ($urandom_range(0, 6) << 2);
        endcase
        wr   = 1'($urandom_range(0, 1));
        data = $urandom;
        strb = wr ? 4'($urandom_range(0, 15)) : (($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
        do_txn(d, wr, addr, data, strb, rd, err, cyc, er, ee);
        n_chk++; if (cyc !== ws[d] + 2) $display("FAIL rnd_latency[%0d] #%0d: got %0d want %0d", d, n, cyc, ws[d] + 2); else n_pass++;
        n_chk++; if (err !== ee) $display("FAIL rnd_pslverr[%0d] #%0d addr %h: got %b want %b", d, n, addr, err, ee); else n_pass++;
        if (!wr) begin
          n_chk++; if (rd !== er) $display("FAIL rnd_prdata[%0d] #%0d addr %h: got %h want %h", d, n, addr, rd, er); else n_pass++;
        end
        if ($urandom_range(0, 3) == 0) idle(d);
      end
      idle(d);
      @(posedge clk); #1;
      n_chk++; if (regs[d] !== pack_model(d)) $display("FAIL rnd_regs_o[%0d]: got %h want %h", d, regs[d], pack_model(d)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id();
    test_errors();
    test_abort();
    test_back_to_back();
`ifdef APB_SLV_PSTRB_EN
    test_strobe();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
